// File: rtl/code_display_sequencer_pkg.sv
// Shared display definitions: 7-segment patterns (bit order [0:6] = a..g) and FSM states.
// Digit patterns are stored active-high; seg_of_digit returns the active-low pin value.
package display_pkg;

    typedef logic [0:6] seg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
    };

    localparam seg_t SEG_DASH  = ~7'b0000001;
    localparam seg_t SEG_BLANK = ~7'b0000000;

    function automatic seg_t seg_of_digit(input logic [3:0] d);
        return (d < 4'd10) ? ~SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/code_display_sequencer_if.sv
// Producer-side handshake and HEX display bus of the code display sequencer.
// master = encoder/producer side, slave = the sequencer.
interface code_display_sequencer_if;
    import display_pkg::*;

    logic       in_valid;
    logic [3:0] in_code;
    logic       in_ready;
    logic       clear;
    seg_t       seg_left;
    seg_t       seg_right;
    logic       busy;
    logic       drop;

    modport master (
        output in_valid, in_code, clear,
        input  in_ready, seg_left, seg_right, busy, drop
    );

    modport slave (
        input  in_valid, in_code, clear,
        output in_ready, seg_left, seg_right, busy, drop
    );

endinterface

// File: rtl/code_display_sequencer_fifo.sv
// In-order synchronous FIFO of 4-bit codes; push on full and pop on empty are ignored.
// clear flushes the contents on the next edge, reset has priority over everything.
module code_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3:0]               din,
    output logic [3:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/code_display_sequencer.sv
// Buffers encoder codes and shows each on HEX1/HEX0 for HOLD_CYCLES, then blanks for GAP_CYCLES.
// Segment, busy and drop outputs are registered from next-state values; in_ready is combinational.
module code_display_sequencer
    import display_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50,
    parameter int GAP_CYCLES  = 5
) (
    input logic                     clk,
    input logic                     reset,
    code_display_sequencer_if.slave bus
);

    localparam int PW     = $clog2(DEPTH);
    localparam int QW     = PW + 1;
    localparam int MAXCYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW     = $clog2(MAXCYC) + 1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic [3:0]  r_code;
    logic [3:0]  w_code_nxt;
    seg_t        r_seg_l;
    seg_t        r_seg_r;
    seg_t        w_seg_l_nxt;
    seg_t        w_seg_r_nxt;
    logic        r_busy;
    logic        r_drop;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [3:0]  w_dout;
    logic [PW:0] w_count;
    logic [PW:0] w_count_nxt;

    function automatic seg_t left_of(input logic [3:0] code);
        return (code >= 4'd10) ? seg_of_digit(4'd1) : SEG_BLANK;
    endfunction

    function automatic seg_t right_of(input logic [3:0] code);
        return (code >= 4'd10) ? seg_of_digit(code - 4'd10) : seg_of_digit(code);
    endfunction

    code_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (bus.clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.in_code),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign bus.in_ready  = (w_count < QW'(DEPTH));
    assign w_push        = bus.in_valid & bus.in_ready & ~bus.clear;
    assign bus.seg_left  = r_seg_l;
    assign bus.seg_right = r_seg_r;
    assign bus.busy      = r_busy;
    assign bus.drop      = r_drop;

    // Pops are only requested on a pre-edge non-empty FIFO, so a code pushed into an
    // empty FIFO is picked up one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == TW'(HOLD_CYCLES - 1)) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == TW'(GAP_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (bus.clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_pop       = 1'b0;
        end
    end

    always_comb begin
        w_code_nxt  = w_pop ? w_dout : r_code;
        w_count_nxt = w_count;
        if (bus.clear) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = w_count + 1'b1;
                2'b01:   w_count_nxt = w_count - 1'b1;
                default: w_count_nxt = w_count;
            endcase
        end
        w_seg_l_nxt = SEG_DASH;
        w_seg_r_nxt = SEG_DASH;
        case (w_state_nxt)
            ST_SHOW: begin
                w_seg_l_nxt = left_of(w_code_nxt);
                w_seg_r_nxt = right_of(w_code_nxt);
            end
            ST_GAP: begin
                w_seg_l_nxt = SEG_BLANK;
                w_seg_r_nxt = SEG_BLANK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_seg_l <= SEG_DASH;
            r_seg_r <= SEG_DASH;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seg_l <= w_seg_l_nxt;
            r_seg_r <= w_seg_r_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
            r_drop  <= bus.in_valid & ~bus.in_ready & ~bus.clear;
        end
    end

    always_ff @(posedge clk) begin
        r_code <= w_code_nxt;
    end

endmodule
